// File: rtl/minute_clock_generator_pkg.sv
// Shared definitions for the minute clock generator: FSM states and
// the seconds-counter constants.
package clock_pkg;

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    RUN      = 2'd1,
    ADV_LOW  = 2'd2,
    ADV_HIGH = 2'd3
  } clk_state_e;

  localparam int SECONDS_PER_MINUTE = 60;
  localparam int HALF_MINUTE        = 30;
  localparam int SECONDS_W          = 6;

endpackage

// File: rtl/minute_clock_generator_if.sv
// Control/status bundle of the minute clock generator; the slave side is
// the generator itself, the master side is whoever drives run/advReq.
interface minute_clock_generator_if;
  import clock_pkg::*;

  logic                 run;
  logic                 advReq;
  logic                 advAck;
  logic                 secondTick;
  logic                 minuteTick;
  logic [SECONDS_W-1:0] seconds;
  logic                 minuteClock;

  modport master (
    output run, advReq,
    input  advAck, secondTick, minuteTick, seconds, minuteClock
  );

  modport slave (
    input  run, advReq,
    output advAck, secondTick, minuteTick, seconds, minuteClock
  );
endinterface

// File: rtl/minute_clock_generator_tick_prescaler.sv
// Modulo-N counter with enable and synchronous clear; tc_o flags the
// terminal value N-1 regardless of enable.
module tick_prescaler #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/minute_clock_generator.sv
// Seconds timekeeper producing a once-per-minute square wave, with a
// fast-advance sequence that inserts one extra minuteClock pulse on request.
module minute_clock_generator
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int ADV_HALF = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  minute_clock_generator_if.slave  bus
);
  localparam int AW = $clog2(ADV_HALF + 1);

  clk_state_e           state_q, state_d;
  logic [AW-1:0]        adv_cnt_q, adv_cnt_d;
  logic [SECONDS_W-1:0] sec_q, sec_d;
  logic                 mclk_q, mclk_d;
  logic                 presc_tc, presc_en, presc_clr;
  logic                 adv_last, adv_go, tick;

  tick_prescaler #(.N(CLK_HZ)) u_presc (
    .clk   (clock),
    .rst_n (resetN),
    .en_i  (presc_en),
    .clr_i (presc_clr),
    .tc_o  (presc_tc)
  );

  assign adv_last = (adv_cnt_q == AW'(ADV_HALF - 1));
  assign bus.advAck = (state_q == ADV_HIGH) && adv_last;
  assign adv_go = bus.advReq && !bus.advAck;

  always_comb begin
    state_d   = state_q;
    adv_cnt_d = adv_cnt_q;
    sec_d     = sec_q;
    mclk_d    = mclk_q;
    tick      = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    unique case (state_q)
      STOP: begin
        if (adv_go) begin
          state_d   = ADV_LOW;
          adv_cnt_d = '0;
        end else if (bus.run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A wrap landing on the advance-entry cycle is dropped with the tick.
        if (adv_go) begin
          state_d   = ADV_LOW;
          adv_cnt_d = '0;
        end else begin
          presc_en = 1'b1;
          tick     = presc_tc;
          if (!bus.run) state_d = STOP;
        end
      end
      ADV_LOW: begin
        adv_cnt_d = adv_cnt_q + AW'(1);
        if (adv_last) begin
          state_d   = ADV_HIGH;
          adv_cnt_d = '0;
        end
      end
      ADV_HIGH: begin
        adv_cnt_d = adv_cnt_q + AW'(1);
        if (adv_last) begin
          adv_cnt_d = '0;
          presc_clr = 1'b1;
          sec_d     = '0;
          // A still-held request chains straight into the next low phase.
          if (bus.advReq)   state_d = ADV_LOW;
          else if (bus.run) state_d = RUN;
          else              state_d = STOP;
        end
      end
      default: state_d = STOP;
    endcase

    if (tick) begin
      sec_d = (sec_q == SECONDS_W'(SECONDS_PER_MINUTE - 1)) ? '0 : sec_q + SECONDS_W'(1);
      if (sec_d == '0)                         mclk_d = 1'b1;
      else if (sec_d == SECONDS_W'(HALF_MINUTE)) mclk_d = 1'b0;
    end

    // The register is loaded from the next state so the forced level is
    // visible for exactly the cycles spent in each advance phase.
    if (state_d == ADV_LOW)       mclk_d = 1'b0;
    else if (state_d == ADV_HIGH) mclk_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= STOP;
      adv_cnt_q <= '0;
      sec_q     <= '0;
      mclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      adv_cnt_q <= adv_cnt_d;
      sec_q     <= sec_d;
      mclk_q    <= mclk_d;
    end
  end

  assign bus.secondTick  = tick;
  assign bus.minuteTick  = tick && (sec_q == SECONDS_W'(SECONDS_PER_MINUTE - 1));
  assign bus.seconds     = sec_q;
  assign bus.minuteClock = mclk_q;
endmodule

// File: tb/tb_minute_clock_generator.sv
// Scenario bench for minute_clock_generator with CLK_HZ=4, ADV_HALF=2.
module tb_minute_clock_generator;
  localparam int CLK_HZ   = 4;
  localparam int ADV_HALF = 2;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  minute_clock_generator_if bus ();

  minute_clock_generator #(.CLK_HZ(CLK_HZ), .ADV_HALF(ADV_HALF)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct packed {
    logic [5:0] sec;
    logic       st;
    logic       mt;
    logic       mc;
    logic       ack;
  } obs_t;

  typedef struct packed {
    logic r;
    logic a;
  } stim_t;

  obs_t  sbq[$];
  stim_t stq[$];
  int    n_pass  = 0;
  int    n_total = 0;

  // Expected outputs for the i-th cycle spent in RUN since reset, treating
  // a minute as 60*CLK_HZ run cycles; minuteClock stays low until the first wrap.
  function automatic obs_t run_exp(int i, bit tick_ok);
    obs_t e;
    int   s, m;
    s     = (i / CLK_HZ) % 60;
    m     = (i / CLK_HZ) / 60;
    e.sec = 6'(s);
    e.st  = tick_ok && ((i % CLK_HZ) == CLK_HZ - 1);
    e.mt  = e.st && (s == 59);
    e.mc  = (m != 0) && (s < 30);
    e.ack = 1'b0;
    return e;
  endfunction

  function automatic obs_t adv_exp(int s, bit mc, bit ack);
    obs_t e;
    e.sec = 6'(s);
    e.st  = 1'b0;
    e.mt  = 1'b0;
    e.mc  = mc;
    e.ack = ack;
    return e;
  endfunction

  task automatic plan(input logic r, input logic a, input obs_t e);
    stim_t s;
    s.r = r;
    s.a = a;
    stq.push_back(s);
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic a, output obs_t o);
    bus.run    = r;
    bus.advReq = a;
    #1;
    o = {bus.seconds, bus.secondTick, bus.minuteTick, bus.minuteClock, bus.advAck};
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.run    = 1'b0;
    bus.advReq = 1'b0;
    resetN     = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    apply_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, o);
    #1;
    n_total++;
    if (bus.seconds !== 6'd2) $display("FAIL reset_pre sec: got %0d want 2", bus.seconds);
    else n_pass++;
    resetN = 1'b0;
    #1;
    o = {bus.seconds, bus.secondTick, bus.minuteTick, bus.minuteClock, bus.advAck};
    n_total++;
    if (o !== '0) $display("FAIL reset_async: got %b want 0", o);
    else n_pass++;
    @(posedge clock);
    #2;
    o = {bus.seconds, bus.secondTick, bus.minuteTick, bus.minuteClock, bus.advAck};
    n_total++;
    if (o !== '0) $display("FAIL reset_held: got %b want 0", o);
    else n_pass++;
    resetN = 1'b1;
  endtask

  task automatic test_run_minute();
    obs_t o, e;
    stim_t s;
    int c = 0, n_st = 0, n_mt = 0, n_edge = 0;
    logic prev = 1'b0;
    apply_reset();
    plan(1'b1, 1'b0, run_exp(0, 1'b0));
    for (int i = 0; i < 244; i++) plan(1'b1, 1'b0, run_exp(i, 1'b1));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      cyc(s.r, s.a, o);
      e = sbq.pop_front();
      n_total++;
      if (o !== e) $display("FAIL run_minute cyc %0d: got sec=%0d st/mt/mc/ack=%b want sec=%0d st/mt/mc/ack=%b", c, o.sec, o[3:0], e.sec, e[3:0]);
      else n_pass++;
      if (o.st) n_st++;
      if (o.mt) n_mt++;
      if (o.mc && !prev) n_edge++;
      prev = o.mc;
      c++;
    end
    n_total++;
    if (n_st !== 61) $display("FAIL run_minute secondTicks: got %0d want 61", n_st); else n_pass++;
    n_total++;
    if (n_mt !== 1) $display("FAIL run_minute minuteTicks: got %0d want 1", n_mt); else n_pass++;
    n_total++;
    if (n_edge !== 1) $display("FAIL run_minute mclk_edges: got %0d want 1", n_edge); else n_pass++;
  endtask

  task automatic test_stop_hold();
    obs_t o, e;
    stim_t s;
    int c = 0, n_st = 0;
    apply_reset();
    plan(1'b1, 1'b0, run_exp(0, 1'b0));
    for (int i = 0; i < 70; i++) plan(i != 69, 1'b0, run_exp(i, 1'b1));
    for (int i = 0; i < 50; i++) plan(1'b0, 1'b0, run_exp(70, 1'b0));
    plan(1'b1, 1'b0, run_exp(70, 1'b0));
    for (int i = 70; i < 82; i++) plan(1'b1, 1'b0, run_exp(i, 1'b1));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      cyc(s.r, s.a, o);
      e = sbq.pop_front();
      n_total++;
      if (o !== e) $display("FAIL stop_hold cyc %0d: got sec=%0d st/mt/mc/ack=%b want sec=%0d st/mt/mc/ack=%b", c, o.sec, o[3:0], e.sec, e[3:0]);
      else n_pass++;
      if (o.st) n_st++;
      c++;
    end
    n_total++;
    if (n_st !== 20) $display("FAIL stop_hold secondTicks: got %0d want 20", n_st); else n_pass++;
  endtask

  task automatic test_advance();
    obs_t o, e;
    stim_t s;
    int c = 0, n_ack = 0, n_edge = 0;
    logic prev = 1'b0;
    apply_reset();
    plan(1'b1, 1'b0, run_exp(0, 1'b0));
    for (int i = 0; i <= 170; i++) plan(1'b1, i == 170, run_exp(i, 1'b1));
    for (int j = 0; j < 4; j++) plan(1'b1, 1'b0, adv_exp(42, j >= 2, j == 3));
    for (int k = 0; k <= 6; k++) plan(1'b1, k == 6, run_exp(240 + k, 1'b1));
    for (int j = 0; j < 4; j++) plan(1'b1, 1'b0, adv_exp(1, j >= 2, j == 3));
    for (int k = 0; k < 8; k++) plan(1'b1, 1'b0, run_exp(240 + k, 1'b1));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      cyc(s.r, s.a, o);
      e = sbq.pop_front();
      n_total++;
      if (o !== e) $display("FAIL advance cyc %0d: got sec=%0d st/mt/mc/ack=%b want sec=%0d st/mt/mc/ack=%b", c, o.sec, o[3:0], e.sec, e[3:0]);
      else n_pass++;
      if (o.ack) n_ack++;
      if (o.mc && !prev) n_edge++;
      prev = o.mc;
      c++;
    end
    n_total++;
    if (n_ack !== 2) $display("FAIL advance acks: got %0d want 2", n_ack); else n_pass++;
    n_total++;
    if (n_edge !== 2) $display("FAIL advance mclk_edges: got %0d want 2", n_edge); else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    stim_t s;
    int c = 0, n_ack = 0, n_st = 0;
    int edges[$];
    logic prev = 1'b0;
    apply_reset();
    plan(1'b1, 1'b0, run_exp(0, 1'b0));
    for (int i = 0; i < 7; i++) plan(1'b1, 1'b0, run_exp(i, 1'b1));
    plan(1'b1, 1'b1, run_exp(7, 1'b0));
    for (int n = 0; n < 3; n++)
      for (int j = 0; j < 4; j++)
        plan(1'b1, !(n == 2 && j == 3), adv_exp((n == 0) ? 1 : 0, j >= 2, j == 3));
    for (int k = 0; k < 6; k++) plan(1'b1, 1'b0, run_exp(240 + k, 1'b1));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      cyc(s.r, s.a, o);
      e = sbq.pop_front();
      n_total++;
      if (o !== e) $display("FAIL back_to_back cyc %0d: got sec=%0d st/mt/mc/ack=%b want sec=%0d st/mt/mc/ack=%b", c, o.sec, o[3:0], e.sec, e[3:0]);
      else n_pass++;
      if (o.ack) n_ack++;
      if (o.st) n_st++;
      if (o.mc && !prev) edges.push_back(c);
      prev = o.mc;
      c++;
    end
    n_total++;
    if (n_ack !== 3) $display("FAIL back_to_back acks: got %0d want 3", n_ack); else n_pass++;
    n_total++;
    if (n_st !== 2) $display("FAIL back_to_back secondTicks: got %0d want 2", n_st); else n_pass++;
    n_total++;
    if (edges.size() !== 3) $display("FAIL back_to_back mclk_edges: got %0d want 3", edges.size());
    else begin
      n_pass++;
      n_total++;
      if ((edges[1] - edges[0]) !== 4 || (edges[2] - edges[1]) !== 4)
        $display("FAIL back_to_back period: got %0d,%0d want 4,4", edges[1] - edges[0], edges[2] - edges[1]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_advance();
    obs_t o, e;
    stim_t s;
    int c = 0, n_mt = 0, n_ack = 0, n_edge = 0;
    logic prev = 1'b0;
    apply_reset();
    plan(1'b1, 1'b0, run_exp(0, 1'b0));
    for (int i = 0; i < 240; i++) plan(1'b1, i == 239, run_exp(i, i != 239));
    for (int j = 0; j < 4; j++) plan(1'b1, 1'b0, adv_exp(59, j >= 2, j == 3));
    for (int k = 0; k < 6; k++) plan(1'b1, 1'b0, run_exp(240 + k, 1'b1));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      cyc(s.r, s.a, o);
      e = sbq.pop_front();
      n_total++;
      if (o !== e) $display("FAIL wrap_advance cyc %0d: got sec=%0d st/mt/mc/ack=%b want sec=%0d st/mt/mc/ack=%b", c, o.sec, o[3:0], e.sec, e[3:0]);
      else n_pass++;
      if (o.mt) n_mt++;
      if (o.ack) n_ack++;
      if (o.mc && !prev) n_edge++;
      prev = o.mc;
      c++;
    end
    n_total++;
    if (n_mt !== 0) $display("FAIL wrap_advance minuteTicks: got %0d want 0", n_mt); else n_pass++;
    n_total++;
    if (n_edge !== 1 || n_ack !== 1) $display("FAIL wrap_advance edges/acks: got %0d/%0d want 1/1", n_edge, n_ack);
    else n_pass++;
  endtask

  task automatic test_reset_mid_adv();
    obs_t o, e;
    stim_t s;
    int c = 0, n_ack = 0;
    apply_reset();
    plan(1'b1, 1'b0, run_exp(0, 1'b0));
    for (int i = 0; i < 3; i++) plan(1'b1, i == 2, run_exp(i, 1'b1));
    plan(1'b1, 1'b0, adv_exp(0, 1'b0, 1'b0));
    plan(1'b1, 1'b0, adv_exp(0, 1'b0, 1'b0));
    plan(1'b1, 1'b0, adv_exp(0, 1'b1, 1'b0));
    for (int pass = 0; pass < 2; pass++) begin
      while (stq.size() != 0) begin
        s = stq.pop_front();
        cyc(s.r, s.a, o);
        e = sbq.pop_front();
        n_total++;
        if (o !== e) $display("FAIL reset_mid_adv cyc %0d: got sec=%0d st/mt/mc/ack=%b want sec=%0d st/mt/mc/ack=%b", c, o.sec, o[3:0], e.sec, e[3:0]);
        else n_pass++;
        if (o.ack) n_ack++;
        c++;
      end
      if (pass == 0) begin
        // now in the final high cycle of the advance, where advAck would fire
        bus.advReq = 1'b0;
        resetN     = 1'b0;
        #1;
        o = {bus.seconds, bus.secondTick, bus.minuteTick, bus.minuteClock, bus.advAck};
        n_total++;
        if (o !== '0) $display("FAIL reset_mid_adv async: got %b want 0", o); else n_pass++;
        @(posedge clock);
        #2;
        o = {bus.seconds, bus.secondTick, bus.minuteTick, bus.minuteClock, bus.advAck};
        n_total++;
        if (o !== '0) $display("FAIL reset_mid_adv held: got %b want 0", o); else n_pass++;
        resetN = 1'b1;
        plan(1'b0, 1'b0, run_exp(0, 1'b0));
        plan(1'b0, 1'b0, run_exp(0, 1'b0));
        plan(1'b1, 1'b0, run_exp(0, 1'b0));
        for (int i = 0; i < 6; i++) plan(1'b1, 1'b0, run_exp(i, 1'b1));
      end
    end
    n_total++;
    if (n_ack !== 0) $display("FAIL reset_mid_adv acks: got %0d want 0", n_ack); else n_pass++;
  endtask

  initial begin
    bus.run    = 1'b0;
    bus.advReq = 1'b0;
    test_reset();
    test_run_minute();
    test_stop_hold();
    test_advance();
    test_back_to_back();
    test_wrap_advance();
    test_reset_mid_adv();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/minute_clock_generator.md
MINUTE_CLOCK_GENERATOR -- requirements
Module: minute_clock_generator

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock cycles per second (min 2).
REQ-002 Parameter ADV_HALF, default 4, cycles per half-period of a fast-advance minuteClock pulse (min 1).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  system clock, all state on rising edge.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 run  input  1  level; 1 = timekeeping advances, 0 = hold.
REQ-007 advReq  input  1  level request to insert one fast minute.
REQ-008 advAck  output  1  one-cycle pulse, advance complete.
REQ-009 secondTick  output  1  one-cycle pulse per elapsed second.
REQ-010 minuteTick  output  1  one-cycle pulse on the 59->0 seconds wrap.
REQ-011 seconds  output  6  current second, 0..59.
REQ-012 minuteClock  output  1  square wave, rising edge once per minute; drives the hour counter's minuteClock.

Function
REQ-013 FSM states STOP, RUN, ADV_LOW, ADV_HIGH.
REQ-014 STOP->RUN when run=1; RUN->STOP when run=0; both take effect the next cycle.
REQ-015 STOP or RUN -> ADV_LOW when advReq=1 and advAck=0; advReq takes priority over run.
REQ-016 In RUN, the prescaler counts 0..CLK_HZ-1 and wraps; secondTick=1 in the cycle the prescaler equals CLK_HZ-1.
REQ-017 In STOP, prescaler, seconds and minuteClock hold; secondTick and minuteTick stay 0.
REQ-018 seconds increments on secondTick and wraps 59->0; minuteTick=1 in the same cycle as that wrapping secondTick.
REQ-019 minuteClock registered: set to 1 on the cycle seconds becomes 0, cleared on the cycle seconds becomes 30; one rising edge per 60 s.
REQ-020 ADV_LOW forces minuteClock=0 for ADV_HALF cycles, then goes to ADV_HIGH.
REQ-021 ADV_HIGH forces minuteClock=1 for ADV_HALF cycles; on its last cycle it clears prescaler and seconds to 0 and pulses advAck.
REQ-022 After ADV_HIGH, the FSM goes to RUN if run=1, else STOP.
REQ-023 A held advReq yields back-to-back advances; each completes with exactly one advAck.
REQ-024 secondTick and minuteTick are 0 throughout ADV_LOW/ADV_HIGH; a natural wrap coincident with advance entry is discarded.
REQ-025 Exactly one minuteClock rising edge per advance, none lost or duplicated at entry/exit.
REQ-026 Prescaler width is ceil(log2(CLK_HZ)); arithmetic is unsigned with no overflow beyond the wrap.

Reset
REQ-027 resetN=0 asynchronously forces STOP, prescaler=0, seconds=0, minuteClock=0, secondTick=0, minuteTick=0, advAck=0.
REQ-028 Reset mid-advance abandons the advance with no advAck; normal operation resumes on the first clock after resetN rises.

Structure
REQ-029 Shared package clock_pkg holds the FSM state enumeration and the constants SECONDS_PER_MINUTE=60 and HALF_MINUTE=30.
REQ-030 Sub-module tick_prescaler is a parameterised modulo-N counter with enable, synchronous clear and terminal-count output, instantiated once.

Verification (CLK_HZ=4, ADV_HALF=2)
REQ-031 Reset then run=1 for 240 cycles -> 60 secondTick pulses, seconds 0..59..0, one minuteTick, minuteClock low at seconds=30 and rising at wrap.
REQ-032 run=0 at seconds=17 for 50 cycles -> seconds stays 17, no ticks; run=1 -> counting resumes from the held prescaler value.
REQ-033 advReq=1 for one cycle at seconds=42 -> minuteClock low 2 cycles then high 2 cycles, advAck one pulse, seconds=0 afterward.
REQ-034 advReq held for 3 advAck pulses -> exactly 3 minuteClock rising edges, 4-cycle period.
REQ-035 advReq asserted in the cycle of the 59->0 wrap -> no minuteTick, single advance edge.
REQ-036 resetN=0 during ADV_HIGH -> all outputs 0 immediately, no advAck, STOP state.
